// File: rtl/bin_to_bcd_digits.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_digits
// Purpose  : Sequential double-dabble binary-to-BCD converter (one bit per
//            clock) that produces four saturating display digits.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_digits #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             blank,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       digit3,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic             display_on
);

    localparam int                 c_SR_W     = WIDTH + 16;
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [31:0]        c_MAX      = 32'(MAX_VAL);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_SR_W-1:0]   r_shift;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ovf_pending;
    logic                r_seen;

    logic [c_SR_W-1:0]   w_adj;
    logic [c_SR_W-1:0]   w_next;
    logic                w_finish;
    logic                w_ovf_in;

    // Low bits still holding unconverted binary pass through untouched.
    assign w_adj[WIDTH-1:0] = r_shift[WIDTH-1:0];

    for (genvar i = 0; i < 4; i++) begin : g_add3
        logic [3:0] w_nib;
        assign w_nib = r_shift[WIDTH+4*i +: 4];
        assign w_adj[WIDTH+4*i +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    assign w_next   = {w_adj[c_SR_W-2:0], 1'b0};
    assign w_finish = (r_state == ST_SHIFT) && (r_count == c_CNT_ONE);
    assign w_ovf_in = {{(32-WIDTH){1'b0}}, bin_in} > c_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_count       <= '0;
            r_ovf_pending <= 1'b0;
            r_seen        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            digit3        <= 4'd0;
            digit2        <= 4'd0;
            digit1        <= 4'd0;
            digit0        <= 4'd0;
            display_on    <= 1'b0;
        end else begin
            done       <= 1'b0;
            // Display comes on only once real digits exist, and blank wins.
            display_on <= ~blank & (r_seen | w_finish);
            if (w_finish) begin
                r_seen <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift       <= {16'd0, bin_in};
                        r_ovf_pending <= w_ovf_in;
                        r_count       <= c_CNT_LOAD;
                        busy          <= 1'b1;
                        r_state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= w_next;
                    r_count <= r_count - c_CNT_ONE;
                    if (r_count == c_CNT_ONE) begin
                        if (r_ovf_pending) begin
                            {digit3, digit2, digit1, digit0} <= 16'h9999;
                        end else begin
                            {digit3, digit2, digit1, digit0} <= w_next[c_SR_W-1:WIDTH];
                        end
                        overflow <= r_ovf_pending;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_digits.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_digits
// Purpose  : Self-checking bench: vector table, random values against an
//            arithmetic model, and handshake / reset / blank sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_digits;

    localparam int WIDTH   = 14;
    localparam int LATENCY = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             blank = 1'b0;
    logic [WIDTH-1:0] bin_in = '0;
    logic             busy, done, overflow, display_on;
    logic [3:0]       digit3, digit2, digit1, digit0;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] prev_digits = 16'h0000;

    bin_to_bcd_digits #(.WIDTH(WIDTH), .MAX_VAL(9999)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .blank      (blank),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .display_on (display_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          value;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [15:0] digits_now();
        return {digit3, digit2, digit1, digit0};
    endfunction

    // Reference: decimal digits of the value, saturated at 9999.
    function automatic logic [15:0] model_bcd(int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts a conversion from a point just after a rising edge, returns just
    // after the edge on which done is seen.
    task automatic do_conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
        int   cyc;
        logic hold_ok;
        start  = 1'b1;
        bin_in = WIDTH'(v);
        @(posedge clk); #1;
        start  = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        cyc     = 0;
        hold_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (digits_now() !== prev_digits) hold_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold_during_conv", int'(hold_ok), 1);
        chk("latency", cyc, LATENCY);
        chk("digits", int'(digits_now()), int'(exp_bcd));
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("busy_at_done", int'(busy), 0);
        chk("display_on_at_done", int'(display_on), 1);
        prev_digits = exp_bcd;
    endtask

    initial begin
        int          n_done;
        int          done_cyc;
        int          v;
        logic        hold_ok;

        tbl[0]  = '{1234,  16'h1234, 1'b0};
        tbl[1]  = '{0,     16'h0000, 1'b0};
        tbl[2]  = '{9999,  16'h9999, 1'b0};
        tbl[3]  = '{10000, 16'h9999, 1'b1};
        tbl[4]  = '{16383, 16'h9999, 1'b1};
        tbl[5]  = '{5,     16'h0005, 1'b0};
        tbl[6]  = '{10,    16'h0010, 1'b0};
        tbl[7]  = '{99,    16'h0099, 1'b0};
        tbl[8]  = '{100,   16'h0100, 1'b0};
        tbl[9]  = '{1000,  16'h1000, 1'b0};
        tbl[10] = '{8765,  16'h8765, 1'b0};
        tbl[11] = '{5050,  16'h5050, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_digits", int'(digits_now()), 0);
        chk("rst_display_on", int'(display_on), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_display_on", int'(display_on), 0);

        for (int i = 0; i < 12; i++) begin
            do_conv(tbl[i].value, tbl[i].bcd, tbl[i].ovf);
        end

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 16383));
            do_conv(v, model_bcd(v), v > 9999);
        end

        // start while busy is ignored, bin_in changes after acceptance ignored
        @(posedge clk); #1;
        start  = 1'b1;
        bin_in = 14'd1234;
        @(posedge clk); #1;
        start    = 1'b0;
        n_done   = 0;
        done_cyc = 0;
        hold_ok  = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 3) begin start = 1'b1; bin_in = 14'd5678; end
            if (cyc == 4) start = 1'b0;
            if (cyc == 6) bin_in = 14'd777;
            if (n_done == 0 && digits_now() !== prev_digits) hold_ok = 1'b0;
            @(posedge clk); #1;
            if (done) begin n_done++; done_cyc = cyc; end
        end
        chk("busy_ignore_done_count", n_done, 1);
        chk("busy_ignore_latency", done_cyc, LATENCY);
        chk("busy_ignore_digits", int'(digits_now()), 16'h1234);
        chk("busy_ignore_hold", int'(hold_ok), 1);
        prev_digits = 16'h1234;

        // start during the done cycle is accepted
        do_conv(7, 16'h0007, 1'b0);
        chk("b2b_in_done_cycle", int'(done), 1);
        do_conv(42, 16'h0042, 1'b0);

        // reset in the middle of a conversion
        start  = 1'b1;
        bin_in = 14'd4321;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_digits", int'(digits_now()), 0);
        chk("midrst_display_on", int'(display_on), 0);
        chk("midrst_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        chk("midrst_display_stays_off", int'(display_on), 0);
        prev_digits = 16'h0000;
        do_conv(4321, 16'h4321, 1'b0);

        // blank
        blank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("blank_display_off", int'(display_on), 0);
        end
        blank = 1'b0;
        @(posedge clk); #1;
        chk("blank_release", int'(display_on), 1);
        chk("blank_digits_kept", int'(digits_now()), 16'h4321);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_digits.md
Name: bin_to_bcd_digits

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Converts a binary count into four BCD digits.
- Sits directly upstream of display_driver and drives its digit3..digit0 and display_on inputs.
- Start/busy/done handshake. Digit outputs stay stable between conversions, so the multiplexed display never shows partial results.

Parameters:
- WIDTH, 14, bit width of bin_in. Legal range 4..14. The displayable maximum is fixed at 9999.
- MAX_VAL, 9999, saturation threshold. Values above it are flagged as overflow.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs
- start  input  1  request a conversion of bin_in; sampled on rising edge
- blank  input  1  synchronous display blank request; forces display_on low while high
- bin_in  input  WIDTH  unsigned binary value to convert; sampled only when start is accepted
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when new digits are valid
- overflow  output  1  last accepted bin_in exceeded MAX_VAL
- digit3  output  4  BCD thousands digit (to display_driver)
- digit2  output  4  BCD hundreds digit
- digit1  output  4  BCD tens digit
- digit0  output  4  BCD ones digit
- display_on  output  1  enable for display_driver

Behaviour:
- Reset values (asynchronous, immediate on rst=1): state IDLE, busy=0, done=0, overflow=0, digit3..digit0=0, display_on=0, internal shift register and bit counter =0.
- States:
  - IDLE:
    - busy=0.
    - start=1 at a rising edge: latch bin_in into the low WIDTH bits of a (WIDTH+16)-bit shift register and clear the BCD field.
    - Latch ovf_pending = (bin_in > MAX_VAL).
    - Load the bit counter with WIDTH and go to SHIFT. busy=1 from that edge.
  - SHIFT:
    - Each cycle, in order: any BCD nibble >= 5 gets +3, then the whole register shifts left by 1. The counter decrements.
    - When the counter reaches 1 at an edge, that edge performs the final shift, then:
      - writes digits from the BCD field, or 9,9,9,9 if ovf_pending;
      - sets overflow = ovf_pending;
      - sets done=1 and busy=0;
      - returns to IDLE.
- Latency: start accepted at edge E0 → digits, overflow and done update at edge E0+WIDTH (14 cycles by default). done is high for exactly one cycle.
- Outputs between conversions:
  - digit3..digit0 and overflow hold the previous result for the whole conversion.
  - Intermediate values never appear on the outputs.
- Handshake:
  - start while busy=1 is ignored. No queueing.
  - bin_in changes after acceptance have no effect.
  - start in the cycle where done=1 is accepted, because the state is already IDLE. The next done follows WIDTH cycles later.
- display_on:
  - 0 after reset.
  - Set to 1 at the first completed conversion, and stays 1.
  - blank=1 forces display_on=0 at the next edge. Releasing blank restores 1 at the next edge, but only if at least one conversion has completed since reset.
- Widths:
  - Add-3 is 4-bit per nibble; no carry between nibbles is needed.
  - Upper bits of bin_in beyond WIDTH do not exist. WIDTH<14 zero-extends internally.
- Reset mid-conversion: abort immediately. All outputs return to reset values, and no done pulse is produced.
- bin_in exactly MAX_VAL (9999) → digits 9,9,9,9 with overflow=0.

Test Plan:
- Reset, then start with bin_in=1234 held 1 cycle → busy high 14 cycles; done pulse at 14th edge after acceptance; digits 1,2,3,4; overflow=0; display_on=1.
- bin_in=0 → digits 0,0,0,0, overflow=0. Then bin_in=9999 → 9,9,9,9, overflow=0. Then bin_in=10000 and 16383 → 9,9,9,9, overflow=1.
- Start 1234, then pulse start with bin_in=5678 while busy, and change bin_in mid-conversion → exactly one done; result 1,2,3,4. Digits hold previous value until the done edge.
- Start 42 re-asserted in the done cycle of a prior 7 conversion → digits 0,0,0,7 for 14 cycles, then 0,0,4,2. Two done pulses 14 cycles apart.
- Assert rst 5 cycles into a 4321 conversion → busy=0, digits=0, display_on=0 immediately; no done. A fresh start 4321 afterwards converts correctly.
- After a completed conversion, blank=1 for 3 cycles → display_on=0 those cycles; returns to 1 one edge after release; digits unchanged.
